// File: rtl/us_cmd_dispatch.sv
// ============================================================================
// Module      : us_cmd_dispatch
// Description : Consumer of the upstream command FIFO. Pops one 128-bit entry
//               at a time, serves completions as a single CPL/CPLD request to
//               the TX engine, splits WR32 DMA commands into MWr32 TLPs that
//               never cross a 4KB boundary, and reports finished commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module us_cmd_dispatch #(
    parameter int MAX_PAYLOAD_BYTES = 128,
    parameter int LEN_MAX           = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fifo_empty_i,
    input  logic [127:0] fifo_dout_i,
    output logic         fifo_rd_en_o,
    output logic         tx_req_o,
    output logic [1:0]   tx_kind_o,
    input  logic         tx_ack_i,
    output logic [2:0]   tx_tc_o,
    output logic         tx_td_o,
    output logic         tx_ep_o,
    output logic [1:0]   tx_attr_o,
    output logic [9:0]   tx_len_o,
    output logic [15:0]  tx_rid_o,
    output logic [7:0]   tx_tag_o,
    output logic [7:0]   tx_be_o,
    output logic [6:0]   tx_lower_addr_o,
    output logic [31:0]  tx_addr_o,
    output logic         cmd_compl_o,
    output logic [1:0]   cmd_id_o,
    output logic         busy_o,
    output logic         err_invalid_o
);

    // Remaining-byte counter holds up to 2^LEN_MAX
    localparam int       REM_W       = LEN_MAX + 1;
    localparam logic [1:0] C_TYPE_CPL  = 2'd0;
    localparam logic [1:0] C_TYPE_CPLD = 2'd1;
    localparam logic [1:0] C_TYPE_WR32 = 2'd2;
    localparam logic [1:0] C_KIND_MWR  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POP     = 3'd1,
        S_LATCH   = 3'd2,
        S_CPL_REQ = 3'd3,
        S_WR_REQ  = 3'd4,
        S_DONE    = 3'd5,
        S_DROP    = 3'd6
    } state_t;

    state_t           r_state;
    logic [31:0]      r_cur_addr;
    logic [REM_W-1:0] r_remaining;
    logic [12:0]      r_chunk;
    logic [1:0]       r_cmd_id;

    logic [1:0]       w_type;
    logic [4:0]       w_len_raw;
    logic [4:0]       w_len_clamp;
    logic [31:0]      w_lat_addr;
    logic [REM_W-1:0] w_lat_rem;
    logic [12:0]      w_lat_chunk;
    logic [31:0]      w_next_addr;
    logic [REM_W-1:0] w_next_rem;
    logic [12:0]      w_next_chunk;
    logic             w_unused;

    // Largest legal TLP at addr: bounded by what is left, max payload and
    // the distance to the next 4KB boundary (4096 when exactly aligned).
    function automatic logic [12:0] chunk_of(input logic [31:0] addr,
                                             input logic [REM_W-1:0] rem);
        logic [31:0] room;
        logic [31:0] lim;
        room = 32'd4096 - {20'd0, addr[11:0]};
        lim  = 32'(rem);
        if (32'(MAX_PAYLOAD_BYTES) < lim) lim = 32'(MAX_PAYLOAD_BYTES);
        if (room < lim) lim = room;
        return lim[12:0];
    endfunction

    assign w_type    = fifo_dout_i[63:62];
    assign w_len_raw = fifo_dout_i[61:57];
    assign busy_o    = (r_state != S_IDLE);

    // First-chunk values from the raw entry and next-chunk values from state
    always_comb begin
        w_len_clamp = w_len_raw;
        if (w_len_raw < 5'd2) begin
            w_len_clamp = 5'd2;
        end else if (w_len_raw > 5'(LEN_MAX)) begin
            w_len_clamp = 5'(LEN_MAX);
        end
        w_lat_rem    = {{(REM_W-1){1'b0}}, 1'b1} << w_len_clamp;
        w_lat_addr   = {fifo_dout_i[31:2], 2'b00};
        w_lat_chunk  = chunk_of(w_lat_addr, w_lat_rem);
        w_next_addr  = r_cur_addr + {19'd0, r_chunk};
        w_next_rem   = r_remaining - r_chunk[REM_W-1:0];
        w_next_chunk = chunk_of(w_next_addr, w_next_rem);
    end

    // Upper entry bits and sub-DW chunk bits carry no information here
    assign w_unused = ^{fifo_dout_i[127:64], w_lat_chunk[12], w_lat_chunk[1:0],
                        w_next_chunk[12], w_next_chunk[1:0]};

    // Dispatch FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_chunk         <= '0;
            r_cmd_id        <= '0;
            fifo_rd_en_o    <= 1'b0;
            tx_req_o        <= 1'b0;
            tx_kind_o       <= '0;
            tx_tc_o         <= '0;
            tx_td_o         <= 1'b0;
            tx_ep_o         <= 1'b0;
            tx_attr_o       <= '0;
            tx_len_o        <= '0;
            tx_rid_o        <= '0;
            tx_tag_o        <= '0;
            tx_be_o         <= '0;
            tx_lower_addr_o <= '0;
            tx_addr_o       <= '0;
            cmd_compl_o     <= 1'b0;
            cmd_id_o        <= '0;
            err_invalid_o   <= 1'b0;
        end else begin
            fifo_rd_en_o  <= 1'b0;
            cmd_compl_o   <= 1'b0;
            err_invalid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty_i) begin
                        fifo_rd_en_o <= 1'b1;
                        r_state      <= S_POP;
                    end
                end
                S_POP: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_cmd_id <= fifo_dout_i[56:55];
                    case (w_type)
                        C_TYPE_CPL, C_TYPE_CPLD: begin
                            tx_req_o        <= 1'b1;
                            tx_kind_o       <= w_type;
                            tx_tc_o         <= {2'b00, fifo_dout_i[54]};
                            tx_td_o         <= fifo_dout_i[53];
                            tx_ep_o         <= fifo_dout_i[52];
                            tx_attr_o       <= fifo_dout_i[51:50];
                            tx_len_o        <= fifo_dout_i[49:40];
                            tx_rid_o        <= fifo_dout_i[39:24];
                            tx_tag_o        <= fifo_dout_i[23:16];
                            tx_be_o         <= fifo_dout_i[15:8];
                            tx_lower_addr_o <= fifo_dout_i[6:0];
                            r_state         <= S_CPL_REQ;
                        end
                        C_TYPE_WR32: begin
                            tx_req_o    <= 1'b1;
                            tx_kind_o   <= C_KIND_MWR;
                            r_cur_addr  <= w_lat_addr;
                            r_remaining <= w_lat_rem;
                            r_chunk     <= w_lat_chunk;
                            tx_addr_o   <= w_lat_addr;
                            tx_len_o    <= w_lat_chunk[11:2];
                            r_state     <= S_WR_REQ;
                        end
                        default: begin
                            err_invalid_o <= 1'b1;
                            r_state       <= S_DROP;
                        end
                    endcase
                end
                S_CPL_REQ: begin
                    if (tx_ack_i) begin
                        tx_req_o <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_WR_REQ: begin
                    if (tx_ack_i) begin
                        r_cur_addr  <= w_next_addr;
                        r_remaining <= w_next_rem;
                        if (w_next_rem == '0) begin
                            tx_req_o    <= 1'b0;
                            cmd_compl_o <= 1'b1;
                            cmd_id_o    <= r_cmd_id;
                            r_state     <= S_DONE;
                        end else begin
                            r_chunk   <= w_next_chunk;
                            tx_addr_o <= w_next_addr;
                            tx_len_o  <= w_next_chunk[11:2];
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_DROP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_us_cmd_dispatch.sv
// ============================================================================
// Module      : tb_us_cmd_dispatch
// Description : Directed plus randomized bench for us_cmd_dispatch with a
//               FIFO model, TX-engine responder and chunking reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_us_cmd_dispatch;

    localparam int MPS  = 128;
    localparam int LMAX = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty;
    logic [127:0] fifo_dout = '0;
    logic         fifo_rd_en;
    logic         tx_req;
    logic [1:0]   tx_kind;
    logic         tx_ack = 1'b0;
    logic [2:0]   tx_tc;
    logic         tx_td;
    logic         tx_ep;
    logic [1:0]   tx_attr;
    logic [9:0]   tx_len;
    logic [15:0]  tx_rid;
    logic [7:0]   tx_tag;
    logic [7:0]   tx_be;
    logic [6:0]   tx_lower_addr;
    logic [31:0]  tx_addr;
    logic         cmd_compl;
    logic [1:0]   cmd_id;
    logic         busy;
    logic         err_invalid;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model: entries written by the stimulus, read on rd_en
    logic [127:0] mem [0:255];
    int n_pushed = 0;
    int n_popped = 0;
    assign fifo_empty = (n_pushed == n_popped);

    // Event counters observed at the active edge
    int n_pops = 0, n_req_cyc = 0, n_compl = 0, n_err = 0;

    always #5 clk = ~clk;

    us_cmd_dispatch #(.MAX_PAYLOAD_BYTES(MPS), .LEN_MAX(LMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty_i(fifo_empty), .fifo_dout_i(fifo_dout), .fifo_rd_en_o(fifo_rd_en),
        .tx_req_o(tx_req), .tx_kind_o(tx_kind), .tx_ack_i(tx_ack),
        .tx_tc_o(tx_tc), .tx_td_o(tx_td), .tx_ep_o(tx_ep), .tx_attr_o(tx_attr),
        .tx_len_o(tx_len), .tx_rid_o(tx_rid), .tx_tag_o(tx_tag), .tx_be_o(tx_be),
        .tx_lower_addr_o(tx_lower_addr), .tx_addr_o(tx_addr),
        .cmd_compl_o(cmd_compl), .cmd_id_o(cmd_id), .busy_o(busy),
        .err_invalid_o(err_invalid)
    );

    // Standard-mode FIFO read (data one cycle after rd_en) and event counting
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            n_pops <= n_pops + 1;
            if (n_popped < n_pushed) begin
                fifo_dout <= mem[n_popped];
                n_popped  <= n_popped + 1;
            end
        end
        if (tx_req)      n_req_cyc <= n_req_cyc + 1;
        if (cmd_compl)   n_compl   <= n_compl + 1;
        if (err_invalid) n_err     <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] e);
        mem[n_pushed] = e;
        n_pushed++;
    endtask

    task automatic wait_req(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic ack_pulse(input int dly);
        repeat (dly) @(negedge clk);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
    endtask

    task automatic do_cpl(input bit kd, input bit tc0, input bit td, input bit ep,
                          input bit [1:0] attr, input bit [9:0] len, input bit [15:0] rid,
                          input bit [7:0] tag, input bit [7:0] be, input bit [7:0] la,
                          input int dly);
        logic [127:0] e;
        logic [63:0]  expf;
        int p0;
        e = {$urandom, $urandom, 1'b0, kd, 5'($urandom), 2'($urandom),
             tc0, td, ep, attr, len, rid, tag, be, la};
        expf = {8'd0, 3'(tc0), td, ep, attr, len, rid, tag, be, la[6:0]};
        p0 = n_pops;
        push(e);
        wait_req("cpl_req_seen");
        chk("cpl_kind", 64'(tx_kind), 64'(kd));
        chk("cpl_fields", {8'd0, tx_tc, tx_td, tx_ep, tx_attr, tx_len, tx_rid, tx_tag,
                           tx_be, tx_lower_addr}, expf);
        repeat (dly) @(negedge clk);
        chk("cpl_req_held", 64'(tx_req), 64'd1);
        ack_pulse(0);
        chk("cpl_req_drop", 64'(tx_req), 64'd0);
        chk("cpl_idle", 64'(busy), 64'd0);
        chk("cpl_one_pop", 64'(n_pops - p0), 64'd1);
    endtask

    // Reference: walk the transfer in legal TLP-sized steps
    task automatic do_wr(input bit [4:0] len, input bit [1:0] id, input bit [31:0] addr,
                         input int dly);
        logic [127:0] e;
        bit [31:0] exp_a[$];
        int        exp_c[$];
        bit [31:0] a;
        int lc, bytes, room, c, p0, c0, d;
        lc = int'(len);
        if (lc < 2) lc = 2;
        if (lc > LMAX) lc = LMAX;
        bytes = 1 << lc;
        a = addr & 32'hFFFF_FFFC;
        while (bytes > 0) begin
            room = 4096 - int'(a % 4096);
            c = bytes;
            if (MPS < c) c = MPS;
            if (room < c) c = room;
            exp_a.push_back(a);
            exp_c.push_back(c);
            a = a + 32'(c);
            bytes = bytes - c;
        end
        e = {$urandom, $urandom, 2'b10, len, id, 23'($urandom), addr};
        p0 = n_pops;
        c0 = n_compl;
        push(e);
        foreach (exp_a[i]) begin
            wait_req($sformatf("wr_req_seen[%0d]", i));
            chk($sformatf("wr_kind[%0d]", i), 64'(tx_kind), 64'd2);
            chk($sformatf("wr_addr[%0d]", i), 64'(tx_addr), 64'(exp_a[i]));
            chk($sformatf("wr_len[%0d]", i), 64'(tx_len), 64'(exp_c[i] / 4));
            chk($sformatf("wr_no_early_compl[%0d]", i), 64'(n_compl - c0), 64'd0);
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            ack_pulse(d);
        end
        chk("wr_compl_pulse", 64'(cmd_compl), 64'd1);
        chk("wr_compl_id", 64'(cmd_id), 64'(id));
        chk("wr_req_low", 64'(tx_req), 64'd0);
        @(negedge clk);
        chk("wr_compl_once", 64'(n_compl - c0), 64'd1);
        chk("wr_idle", 64'(busy), 64'd0);
        chk("wr_one_pop", 64'(n_pops - p0), 64'd1);
    endtask

    task automatic do_bad();
        int r0, e0;
        bit ok;
        r0 = n_req_cyc;
        e0 = n_err;
        push({$urandom, $urandom, 2'b11, 30'($urandom), $urandom});
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (err_invalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bad_err_seen", 64'(ok), 64'd1);
        @(negedge clk);
        chk("bad_err_once", 64'(n_err - e0), 64'd1);
        chk("bad_no_tx", 64'(n_req_cyc - r0), 64'd0);
        chk("bad_idle", 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {6'd0, tx_req, tx_kind, tx_len, tx_addr, cmd_compl, cmd_id, busy,
                            err_invalid, fifo_rd_en, tx_tc, tx_td, tx_ep, tx_attr}, 64'd0);
        chk({tag, "_cpl"}, {25'd0, tx_rid, tx_tag, tx_be, tx_lower_addr}, 64'd0);
    endtask

    initial begin
        int p0, c0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Stray ack while idle must do nothing
        ack_pulse(0);
        chk("stray_ack_idle", 64'(busy), 64'd0);
        chk("stray_ack_noreq", 64'(tx_req), 64'd0);

        do_cpl(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0100, 8'h5A, 8'h0F, 8'h14, 3);
        do_wr(5'd9, 2'd1, 32'h1000_0000, -1);
        do_wr(5'd8, 2'd2, 32'h0000_0FC0, 0);
        do_wr(5'd0, 2'd3, 32'h2000_0004, 1);
        do_wr(5'd20, 2'd0, 32'h3000_0000, -1);
        do_bad();
        do_cpl(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 10'h3FF, 16'hBEEF, 8'hC3, 8'hF0, 8'hFF, 0);

        // Reset during the second MWr of a 512B write
        p0 = n_pops;
        c0 = n_compl;
        push({$urandom, $urandom, 2'b10, 5'd9, 2'd1, 23'd0, 32'h1000_0000});
        wait_req("rst_req1");
        chk("rst_addr1", 64'(tx_addr), 64'h1000_0000);
        ack_pulse(1);
        wait_req("rst_req2");
        chk("rst_addr2", 64'(tx_addr), 64'h1000_0080);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_compl", 64'(n_compl - c0), 64'd0);
        chk("rst_no_repop", 64'(n_pops - p0), 64'd1);
        chk("rst_idle", 64'(busy), 64'd0);
        do_cpl(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 10'd16, 16'h1234, 8'h07, 8'hFF, 8'h40, 1);

        // Randomized entries
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0, 1: do_cpl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                             2'($urandom), 10'($urandom), 16'($urandom), 8'($urandom),
                             8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
                2: do_wr(5'($urandom), 2'($urandom), $urandom, -1);
                default: do_bad();
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
